// File: rtl/adder_core_pkg.sv
// Shared definitions for the adder stage on the AXI-Stream NoC path:
// NoC field widths, the adder's NoC address and the FSM state encoding.
package adder_core_pkg;

  // Datapath and NoC field widths
  localparam int DATAW          = 128;
  localparam int AXIS_MAX_DATAW = 512;
  localparam int AXIS_USERW     = 8;
  localparam int AXIS_DESTW     = 8;
  localparam int AXIS_IDW       = 8;
  localparam int AXIS_STRBW     = AXIS_MAX_DATAW / 8;
  localparam int AXIS_KEEPW     = AXIS_MAX_DATAW / 8;

  // NoC address that routes beats to this adder
  localparam logic [AXIS_DESTW-1:0] ADDER_ADDR = 8'h01;

  // FSM state encoding
  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] RESULT = 1'b1;

endpackage

// File: rtl/adder_core.sv
// adder_core: accumulates operand beats modulo 2^DATA_WIDTH until tlast,
// then presents sum, beat count and source address on a valid/ready
// response port while back-pressuring the input.
// Optional build macro ADDER_OVERFLOW_FLAG_EN adds a sticky carry-out flag
// (response_overflow) covering every addition of the transaction.
module adder_core #(
  parameter int DATA_WIDTH  = adder_core_pkg::DATAW,
  parameter int AXIS_DATAW  = adder_core_pkg::AXIS_MAX_DATAW,
  parameter int AXIS_USERW  = adder_core_pkg::AXIS_USERW,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 axis_adder_interface_tvalid,
  output logic                                 axis_adder_interface_tready,
  input  logic [AXIS_DATAW-1:0]                axis_adder_interface_tdata,
  input  logic                                 axis_adder_interface_tlast,
  input  logic [AXIS_USERW-1:0]                axis_adder_interface_tuser,
  input  logic [adder_core_pkg::AXIS_DESTW-1:0] axis_adder_interface_tdest,
  input  logic [adder_core_pkg::AXIS_IDW-1:0]   axis_adder_interface_tid,
  input  logic [adder_core_pkg::AXIS_STRBW-1:0] axis_adder_interface_tstrb,
  input  logic [adder_core_pkg::AXIS_KEEPW-1:0] axis_adder_interface_tkeep,
  output logic                                 response_valid,
  input  logic                                 response_ready,
  output logic [DATA_WIDTH-1:0]                response_data,
  output logic [COUNT_WIDTH-1:0]               response_count,
`ifdef ADDER_OVERFLOW_FLAG_EN
  output logic                                 response_overflow,
`endif
  output logic [AXIS_USERW-1:0]                response_src
);

  import adder_core_pkg::*;

  logic [0:0]             state_reg;
  logic [DATA_WIDTH-1:0]  sum_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [DATA_WIDTH-1:0]  operand;
  logic [DATA_WIDTH-1:0]  sum_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   beat_fire;

  // Routing fields and the upper tdata bits carry nothing for the adder
  logic unused_inputs;
  assign unused_inputs = ^{axis_adder_interface_tdata[AXIS_DATAW-1:DATA_WIDTH],
                           axis_adder_interface_tdest, axis_adder_interface_tid,
                           axis_adder_interface_tstrb, axis_adder_interface_tkeep};

  assign operand = axis_adder_interface_tdata[DATA_WIDTH-1:0];

  // Input is only open while accumulating and never during reset
  assign axis_adder_interface_tready = (state_reg == ACCUM) && !rst;
  assign beat_fire = axis_adder_interface_tvalid && axis_adder_interface_tready;

  // Beat counter saturates instead of wrapping
  assign count_next = (count_reg == {COUNT_WIDTH{1'b1}}) ? count_reg
                                                         : count_reg + 1'b1;

`ifdef ADDER_OVERFLOW_FLAG_EN
  logic add_carry;
  logic ovf_acc_reg;
  assign {add_carry, sum_next} = {1'b0, sum_reg} + {1'b0, operand};

  // Sticky carry-out across the transaction, latched with the final sum
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc_reg       <= 1'b0;
      response_overflow <= 1'b0;
    end else if (state_reg == ACCUM) begin
      if (beat_fire) begin
        if (axis_adder_interface_tlast) begin
          response_overflow <= ovf_acc_reg | add_carry;
        end else begin
          ovf_acc_reg <= ovf_acc_reg | add_carry;
        end
      end
    end else if (response_ready) begin
      ovf_acc_reg       <= 1'b0;
      response_overflow <= 1'b0;
    end
  end
`else
  assign sum_next = sum_reg + operand;
`endif

  // FSM, accumulator, counter and registered response port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      sum_reg        <= '0;
      count_reg      <= '0;
      response_valid <= 1'b0;
      response_data  <= '0;
      response_count <= '0;
      response_src   <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (beat_fire) begin
            if (axis_adder_interface_tlast) begin
              response_data  <= sum_next;
              response_count <= count_next;
              response_src   <= axis_adder_interface_tuser;
              response_valid <= 1'b1;
              state_reg      <= RESULT;
            end else begin
              sum_reg   <= sum_next;
              count_reg <= count_next;
            end
          end
        end
        default: begin
          // Response held until consumed; then start a fresh transaction
          if (response_ready) begin
            response_valid <= 1'b0;
            sum_reg        <= '0;
            count_reg      <= '0;
            state_reg      <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_core.sv
// Self-checking bench for adder_core: table-driven transactions plus
// hand-written back-pressure, reset-abort and gapped-input sequences.
module tb_adder_core;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tvalid;
  logic          tready;
  logic [511:0]  tdata;
  logic          tlast;
  logic [7:0]    tuser;
  logic [adder_core_pkg::AXIS_DESTW-1:0] tdest;
  logic [adder_core_pkg::AXIS_IDW-1:0]   tid;
  logic [adder_core_pkg::AXIS_STRBW-1:0] tstrb;
  logic [adder_core_pkg::AXIS_KEEPW-1:0] tkeep;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [CW-1:0] resp_count;
  logic [7:0]    resp_src;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic          resp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_core dut (
    .clk                         (clk),
    .rst                         (rst),
    .axis_adder_interface_tvalid (tvalid),
    .axis_adder_interface_tready (tready),
    .axis_adder_interface_tdata  (tdata),
    .axis_adder_interface_tlast  (tlast),
    .axis_adder_interface_tuser  (tuser),
    .axis_adder_interface_tdest  (tdest),
    .axis_adder_interface_tid    (tid),
    .axis_adder_interface_tstrb  (tstrb),
    .axis_adder_interface_tkeep  (tkeep),
    .response_valid              (resp_valid),
    .response_ready              (resp_ready),
    .response_data               (resp_data),
    .response_count              (resp_count),
`ifdef ADDER_OVERFLOW_FLAG_EN
    .response_overflow           (resp_ovf),
`endif
    .response_src                (resp_src)
  );

  typedef struct {
    string           name;
    int              nbeats;
    logic [2:0][DW-1:0] beats;
    logic [7:0]      user;
    logic [DW-1:0]   exp_data;
    logic [CW-1:0]   exp_count;
    logic            exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one beat and wait (bounded) for its handshake; returns #1 after the edge
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [7:0] u);
    int n = 0;
    tdata  = {384'b0, d};
    tlast  = last;
    tuser  = u;
    tvalid = 1'b1;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      errors++;
      $display("FAIL beat_timeout: tready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [5];
  logic [DW-1:0] all_ones;

  initial begin
    all_ones = '1;
    vecs[0] = '{"basic",  3, {128'd3, 128'd2, 128'd1}, 8'h05, 128'd6,  16'd3, 1'b0};
    vecs[1] = '{"single", 1, {128'd0, 128'd0, 128'd42}, 8'h11, 128'd42, 16'd1, 1'b0};
    vecs[2] = '{"wrap",   2, {128'd0, 128'd2, all_ones}, 8'h22, 128'd1, 16'd2, 1'b1};
    vecs[3] = '{"after_wrap", 2, {128'd0, 128'd4, 128'd3}, 8'h33, 128'd7, 16'd2, 1'b0};
    vecs[4] = '{"mid_carry", 3, {128'd5, {1'b1, 127'd0}, {1'b1, 127'd0}}, 8'h44, 128'd5, 16'd3, 1'b1};

    rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = '0;
    tdest = '0; tid = '0; tstrb = '1; tkeep = '1; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready_low", {127'd0, tready}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", {127'd0, resp_valid}, 128'd0);
    check("reset_data", resp_data, 128'd0);
    check("reset_count", {112'd0, resp_count}, 128'd0);
    check("reset_src", {120'd0, resp_src}, 128'd0);
    check("first_cycle_tready", {127'd0, tready}, 128'd1);

    // Table-driven transactions with response_ready held high
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].nbeats; k++)
        send_beat(vecs[i].beats[k], k == vecs[i].nbeats - 1, vecs[i].user);
      check({vecs[i].name, "_valid"}, {127'd0, resp_valid}, 128'd1);
      check({vecs[i].name, "_tready_low"}, {127'd0, tready}, 128'd0);
      check({vecs[i].name, "_data"}, resp_data, vecs[i].exp_data);
      check({vecs[i].name, "_count"}, {112'd0, resp_count}, {112'd0, vecs[i].exp_count});
      check({vecs[i].name, "_src"}, {120'd0, resp_src}, {120'd0, vecs[i].user});
`ifdef ADDER_OVERFLOW_FLAG_EN
      check({vecs[i].name, "_ovf"}, {127'd0, resp_ovf}, {127'd0, vecs[i].exp_ovf});
`endif
      tick();
      check({vecs[i].name, "_valid_drop"}, {127'd0, resp_valid}, 128'd0);
      check({vecs[i].name, "_tready_back"}, {127'd0, tready}, 128'd1);
    end

    // Back-pressure: response held, pending beat 7 not consumed
    resp_ready = 1'b0;
    send_beat(128'd9, 1'b1, 8'h0A);
    tdata = {384'b0, 128'd7}; tlast = 1'b1; tuser = 8'h0B; tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_held", {127'd0, resp_valid}, 128'd1);
      check("bp_data_held", resp_data, 128'd9);
      check("bp_src_held", {120'd0, resp_src}, 128'h0A);
      check("bp_tready_low", {127'd0, tready}, 128'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release_valid", {127'd0, resp_valid}, 128'd0);
    check("bp_release_tready", {127'd0, tready}, 128'd1);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    check("bp_next_valid", {127'd0, resp_valid}, 128'd1);
    check("bp_next_data", resp_data, 128'd7);
    check("bp_next_count", {112'd0, resp_count}, 128'd1);
    check("bp_next_src", {120'd0, resp_src}, 128'h0B);
    tick();

    // Reset mid-stream discards the partial sum
    send_beat(128'd10, 1'b0, 8'h0C);
    send_beat(128'd20, 1'b0, 8'h0C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {127'd0, resp_valid}, 128'd0);
    check("rst_mid_data", resp_data, 128'd0);
    send_beat(128'd5, 1'b1, 8'h0D);
    check("rst_mid_new_valid", {127'd0, resp_valid}, 128'd1);
    check("rst_mid_new_data", resp_data, 128'd5);
    check("rst_mid_new_count", {112'd0, resp_count}, 128'd1);
    tick();

    // Gapped input
    send_beat(128'd4, 1'b0, 8'h0E);
    repeat (3) tick();
    check("gap_no_valid", {127'd0, resp_valid}, 128'd0);
    send_beat(128'd6, 1'b1, 8'h0E);
    check("gap_data", resp_data, 128'd10);
    check("gap_count", {112'd0, resp_count}, 128'd2);
    check("gap_src", {120'd0, resp_src}, 128'h0E);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_core.md
# adder_core

Accumulating adder stage directly downstream of the client on the AXI-Stream NoC path. It accepts a stream of data beats addressed to the adder, sums them modulo 2^DATA_WIDTH, and closes the transaction on the beat carrying tlast. It then presents the final sum, beat count and source address on a valid/ready response port, and holds the input until the response is consumed.

## Interface
Parameters:
- DATA_WIDTH, 128, operand/sum width; the low DATA_WIDTH bits of tdata are used.
- AXIS_DATAW, 512, NoC tdata width (≥ DATA_WIDTH).
- AXIS_USERW, 8, tuser width; carries the source address.
- COUNT_WIDTH, 16, beat-counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- axis_adder_interface_tvalid  in  1  NoC beat valid.
- axis_adder_interface_tready  out  1  beat accepted when high together with tvalid.
- axis_adder_interface_tdata  in  AXIS_DATAW  operand in bits [DATA_WIDTH-1:0]; upper bits ignored.
- axis_adder_interface_tlast  in  1  final beat of the transaction.
- axis_adder_interface_tuser  in  AXIS_USERW  source address.
- Inputs tdest, tid, tstrb and tkeep are present at NoC widths and ignored.
- response_valid  out  1  result available.
- response_ready  in  1  consumer accepts the result.
- response_data  out  DATA_WIDTH  final sum.
- response_count  out  COUNT_WIDTH  beats in the transaction.
- response_src  out  AXIS_USERW  tuser of the tlast beat.

## Operation
- Two-state FSM: ACCUM and RESULT. Reset enters ACCUM.
- Reset clears sum and count to 0, response_valid to 0, and response_data, response_count and response_src to 0.
- tready = (state == ACCUM) && !rst. The block never asserts tready in RESULT.
- **ACCUM, accepted non-last beat:**
  - sum <= sum + operand, wrapping modulo 2^DATA_WIDTH.
  - count <= count + 1, saturating at 2^COUNT_WIDTH−1.
- **ACCUM, accepted tlast beat:**
  - response_data <= sum + operand.
  - response_count <= count + 1 (saturating).
  - response_src <= tuser.
  - response_valid <= 1; state -> RESULT.
- A single tlast beat with no prior beats is legal: sum = operand, count = 1.
- **RESULT:**
  - response_* outputs are held stable while response_valid && !response_ready.
  - On response_valid && response_ready: response_valid <= 0, sum <= 0, count <= 0, state -> ACCUM.
- A tvalid without handshake in ACCUM changes nothing.
- tvalid arriving in RESULT is back-pressured and never lost.
- Reset mid-transaction, in either state, discards the partial sum and any pending response. No response is emitted.

## Timing
- Throughput: one beat per cycle in ACCUM.
- Latency: response_valid rises the cycle after the tlast handshake.
- Minimum turnaround: the response handshake occurs in cycle N, and tready is high in cycle N+1. Each transaction therefore costs beats + 1 cycles minimum with response_ready tied high.
- First cycle after rst deasserts: tready = 1.
- All outputs are registered except tready, which is decoded from state and rst.

## Configuration
- Macro: ADDER_OVERFLOW_FLAG_EN.
- **Defined:**
  - Extra port response_overflow, out, 1 bit.
  - A sticky flag sets whenever any addition in the current transaction, including the tlast beat, carries out of DATA_WIDTH.
  - The flag is registered with response_data, held in RESULT, and cleared on response handshake and on rst.
- **Undefined:** the port and carry logic are absent; wrap behaviour is otherwise identical.

## Structure
- Shared package/header holds:
  - DATAW, AXIS_MAX_DATAW, AXIS_USERW, AXIS_DESTW, AXIS_IDW, AXIS_STRBW and AXIS_KEEPW.
  - The adder NoC address.
  - The FSM state encoding (ACCUM = 0, RESULT = 1).
- No sub-module is required; the accumulator, counter and FSM live in adder_core.

## Test plan
- **Basic sum:** beats 1, 2, 3 (tlast on 3), tuser 0x05, response_ready = 1 → one response: data 6, count 3, src 0x05; tready low for exactly one cycle after the tlast beat.
- **Single-beat transaction:** beat 42 with tlast → data 42, count 1.
- **Back-pressure:** hold response_ready = 0 for 5 cycles after valid while driving tvalid with beat 7 → response stays stable, tready = 0, beat 7 is not consumed; raise ready → next transaction starts with 7.
- **Wrap:** beats 2^DATA_WIDTH−1 and 2 (tlast) → data 1; with ADDER_OVERFLOW_FLAG_EN, response_overflow = 1. Next transaction 3 + 4 → data 7, overflow 0.
- **Reset mid-stream:** beats 10, 20, then rst for one cycle, then 5 (tlast) → data 5, count 1; no response is emitted for the aborted transaction.
- **Gapped input:** beats 4, idle 3 cycles, 6 (tlast) with tvalid toggling → data 10, count 2.
